// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART FIFO blocks (TX and RX side).
// Provides the launch FSM state encoding, default sizes and a depth helper.
package uart_tx_fifo_pkg;

    localparam int DEF_DBIT   = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } launch_state_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter bundle for uart_tx_fifo.
// master: host + transmitter side (drives wr, w_data, tx_done_tick).
// slave : the FIFO (drives flags, count, overflow, tx_start, tx_din, busy).
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DBIT   = DEF_DBIT,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic            wr;
    logic [DBIT-1:0] w_data;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic            tx_done_tick;
    logic            busy;

    modport master (
        output wr, w_data, tx_done_tick,
        input  full, empty, count, overflow,
        input  tx_start, tx_din, busy
    );

    modport slave (
        input  wr, w_data, tx_done_tick,
        output full, empty, count, overflow,
        output tx_start, tx_din, busy
    );

endinterface

// File: rtl/uart_tx_fifo_fifo_ctrl.sv
// Circular FIFO bookkeeping: pointers, occupancy, full/empty, overflow.
// Ports: clk, reset, wr, pop in; push, wptr, rptr, count, full, empty, overflow out.
module uart_tx_fifo_fifo_ctrl
    import uart_tx_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              pop,
    output logic              push,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] rptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(fifo_depth(ADDR_W));

    // Push is judged on the pre-edge full flag, so a same-cycle pop
    // on a full FIFO does not make room for the write.
    assign push  = wr & ~full;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr & full;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer + launch controller feeding a UART transmitter.
// Ports: clk, reset, bus (slave: wr/w_data in, flags/count/overflow, tx_start/tx_din/busy out, tx_done_tick in).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DBIT   = DEF_DBIT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    logic [DBIT-1:0]   mem [fifo_depth(ADDR_W)];
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    launch_state_t     state;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              busy;

    uart_tx_fifo_fifo_ctrl #(.ADDR_W(ADDR_W)) u_fifo_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr       (bus.wr),
        .pop      (pop),
        .push     (push),
        .wptr     (wptr),
        .rptr     (rptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.w_data;
    end

    // A launch consumes the head entry on the same edge it is captured.
    assign pop = (state == ST_IDLE) && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_din   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_din   <= mem[rptr];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_BUSY;
                    end else begin
                        tx_start <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    tx_start <= 1'b0;
                    if (bus.tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.tx_start = tx_start;
    assign bus.tx_din   = tx_din;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
// Ports: none (top-level bench).
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] q[$];
    logic       m_busy;
    logic       m_start;
    logic       m_ovf;
    logic [7:0] m_din;

    function automatic logic [17:0] dvec();
        return {bus.count, bus.full, bus.empty, bus.overflow,
                bus.tx_start, bus.tx_din, bus.busy};
    endfunction

    function automatic logic [17:0] mvec();
        int n;
        n = q.size();
        return {n[4:0], n == 16, n == 0, m_ovf, m_start, m_din, m_busy};
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy  = 1'b0;
        m_start = 1'b0;
        m_ovf   = 1'b0;
        m_din   = 8'h00;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic step(input logic w, input logic [7:0] d, input logic done);
        logic launch;
        logic pre_full;
        bus.wr           = w;
        bus.w_data       = d;
        bus.tx_done_tick = done;
        @(posedge clk);
        launch   = !m_busy && (q.size() != 0);
        pre_full = (q.size() == 16);
        if (m_busy && done) m_busy = 1'b0;
        if (launch) begin
            m_din  = q.pop_front();
            m_busy = 1'b1;
        end
        m_start = launch;
        m_ovf   = w && pre_full;
        if (w && !pre_full) q.push_back(d);
        cyc++;
        #1;
        bus.wr           = 1'b0;
        bus.tx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.wr           = 1'b0;
        bus.w_data       = 8'h00;
        bus.tx_done_tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dvec() !== mvec())
            $display("FAIL reset_state got %h want %h", dvec(), mvec());
        else passed++;
        total++;
        if ({bus.empty, bus.full, bus.busy} !== 3'b100)
            $display("FAIL reset_flags got %b want 100",
                     {bus.empty, bus.full, bus.busy});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0);
        total++;
        if ({bus.empty, bus.tx_start} !== 2'b00)
            $display("FAIL single_write got %b want 00",
                     {bus.empty, bus.tx_start});
        else passed++;
        step(1'b0, 8'h00, 1'b0);
        total++;
        if ({bus.tx_start, bus.tx_din} !== 9'h1A5)
            $display("FAIL single_launch got %h want 1a5",
                     {bus.tx_start, bus.tx_din});
        else passed++;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b0);
            total++;
            if ({bus.tx_start, bus.busy} !== 2'b01 || dvec() !== mvec())
                $display("FAIL single_hold cyc %0d got %h want %h",
                         cyc, dvec(), mvec());
            else passed++;
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.busy, bus.count, bus.empty} !== 7'b0_00000_1)
            $display("FAIL single_done got %b want 0000001",
                     {bus.busy, bus.count, bus.empty});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int   pulses    = 0;
        int   last_done = -100;
        int   timer     = -1;
        logic done;
        logic prev_busy;
        exp = '{8'h11, 8'h22, 8'h33};
        for (int k = 0; k < 80; k++) begin
            done = (timer == 0);
            if (timer >= 0) timer--;
            if (done) last_done = cyc;
            prev_busy = bus.busy;
            step(k < 3, (k < 3) ? exp[k] : 8'h00, done);
            total++;
            if (dvec() !== mvec())
                $display("FAIL b2b_model cyc %0d got %h want %h",
                         cyc, dvec(), mvec());
            else passed++;
            if (bus.tx_start) begin
                total++;
                if (pulses > 2 || prev_busy !== 1'b0 ||
                    bus.tx_din !== exp[pulses % 3])
                    $display("FAIL b2b_pulse %0d got %h busy %b want %h",
                             pulses, bus.tx_din, prev_busy, exp[pulses % 3]);
                else passed++;
                if (pulses > 0) begin
                    total++;
                    if (cyc !== last_done + 2)
                        $display("FAIL b2b_gap got cyc %0d want %0d",
                                 cyc, last_done + 2);
                    else passed++;
                end
                pulses++;
                timer = 9;
            end
        end
        total++;
        if (pulses !== 3)
            $display("FAIL b2b_count got %0d want 3", pulses);
        else passed++;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 18; k++) begin
            step(1'b1, 8'(k), 1'b0);
            total++;
            if (dvec() !== mvec())
                $display("FAIL ovf_model cyc %0d got %h want %h",
                         cyc, dvec(), mvec());
            else passed++;
            if (k == 1) begin
                total++;
                if ({bus.tx_start, bus.tx_din} !== 9'h100)
                    $display("FAIL ovf_first got %h want 100",
                             {bus.tx_start, bus.tx_din});
                else passed++;
            end
            if (k == 16) begin
                total++;
                if ({bus.full, bus.count, bus.overflow} !== 7'b1_10000_0)
                    $display("FAIL ovf_full got %b want 1100000",
                             {bus.full, bus.count, bus.overflow});
                else passed++;
            end
            if (k == 17) begin
                total++;
                if ({bus.overflow, bus.count} !== 6'b1_10000)
                    $display("FAIL ovf_pulse got %b want 110000",
                             {bus.overflow, bus.count});
                else passed++;
            end
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if ({bus.overflow, bus.full} !== 2'b01)
            $display("FAIL ovf_clear got %b want 01",
                     {bus.overflow, bus.full});
        else passed++;
    endtask

    task automatic test_simul();
        logic [7:0] want = 8'h02;
        int   timer = -1;
        logic done;
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (dvec() !== mvec())
            $display("FAIL simul_done got %h want %h", dvec(), mvec());
        else passed++;
        step(1'b1, 8'hEE, 1'b0);
        total++;
        if ({bus.overflow, bus.count, bus.tx_start, bus.tx_din} !==
            {1'b1, 5'd15, 1'b1, 8'h01})
            $display("FAIL simul_popwr got %h want %h",
                     {bus.overflow, bus.count, bus.tx_start, bus.tx_din},
                     {1'b1, 5'd15, 1'b1, 8'h01});
        else passed++;
        timer = 3;
        for (int k = 0; k < 400 && (bus.busy || !bus.empty); k++) begin
            done = (timer == 0);
            if (timer >= 0) timer--;
            step(1'b0, 8'h00, done);
            if (bus.tx_start) begin
                total++;
                if (bus.tx_din !== want || dvec() !== mvec())
                    $display("FAIL simul_drain got %h want %h",
                             bus.tx_din, want);
                else passed++;
                want++;
                timer = 3;
            end
        end
        total++;
        if (want !== 8'h11 || bus.empty !== 1'b1)
            $display("FAIL simul_end got %h/%b want 11/1", want, bus.empty);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] base;
        int   sent  = 0;
        int   recv  = 0;
        int   timer = -1;
        logic done;
        logic w;
        base = 8'($urandom);
        for (int k = 0; k < 2000 && (recv < 40 || bus.busy); k++) begin
            done = (timer == 0);
            if (timer >= 0) timer--;
            w = (sent < 40) && ($urandom_range(0, 2) != 0) && (q.size() < 16);
            step(w, base + 8'(sent), done);
            if (w) sent++;
            total++;
            if (dvec() !== mvec())
                $display("FAIL wrap_model cyc %0d got %h want %h",
                         cyc, dvec(), mvec());
            else passed++;
            if (bus.tx_start) begin
                total++;
                if (bus.tx_din !== base + 8'(recv))
                    $display("FAIL wrap_order %0d got %h want %h",
                             recv, bus.tx_din, base + 8'(recv));
                else passed++;
                recv++;
                timer = $urandom_range(0, 4);
            end
        end
        total++;
        if (recv !== 40 || {bus.empty, bus.count} !== 6'b1_00000)
            $display("FAIL wrap_end got %0d/%b want 40/100000",
                     recv, {bus.empty, bus.count});
        else passed++;
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom), 1'b0);
        total++;
        if ({bus.busy, bus.count} !== 6'b1_00101)
            $display("FAIL rst_pre got %b want 100101",
                     {bus.busy, bus.count});
        else passed++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({bus.count, bus.empty, bus.busy, bus.tx_start} !== 8'b00000_1_0_0
            || dvec() !== mvec())
            $display("FAIL rst_mid got %h want %h", dvec(), mvec());
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (bus.tx_start) starts++;
        end
        total++;
        if (starts !== 0)
            $display("FAIL rst_quiet got %0d want 0", starts);
        else passed++;
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        total++;
        if ({bus.tx_start, bus.tx_din} !== 9'h15A || dvec() !== mvec())
            $display("FAIL rst_relaunch got %h want 15a",
                     {bus.tx_start, bus.tx_din});
        else passed++;
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
